seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, number of clk cycles each digit stays selected (1 kHz digit rate at 50 MHz).
REQ-002 Parameter: DIGITS, default 6, number of display digits; fixed at 6, any other value is illegal.
REQ-003 Port: clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: hour  input  8  binary hour value from the timekeeping stage, legal 0..23.
REQ-006 Port: minu  input  8  binary minute value, legal 0..59.
REQ-007 Port: seco  input  8  binary second value, legal 0..59.
REQ-008 Port: hour_vld / minu_vld / seco_vld  input  1 each  one-cycle pulse, the matching value has changed.
REQ-009 Port: seg  output  8  active-low segments; seg[6:0] = g..a, seg[7] = dp; common-anode.
REQ-010 Port: sel  output  6  active-low digit select, one-hot-low; sel[0] = rightmost digit.

Function
REQ-011 On a vld pulse the block SHALL capture the matching value into a raw register on that same edge and set that field's pending flag.
REQ-012 Fields with no vld pulse SHALL ignore their value inputs.
REQ-013 A single shared converter SHALL turn raw values into BCD tens/ones by repeated subtraction of 10, at most one subtraction per cycle.
REQ-014 Converter FSM states:
- IDLE: select the highest-priority pending field (seco > minu > hour), copy its raw value into a work register, clear its pending flag, go to CONV.
- CONV: if work >= 10, subtract 10 and increment tens; else go to WRITE.
- WRITE: store tens/ones in the field's digit registers, return to IDLE.
REQ-015 Latency from vld pulse to updated digit registers SHALL be at most 12 cycles for one field and at most 36 cycles for three simultaneous fields.
REQ-016 A new vld for a field already being converted SHALL update its raw register and re-set its pending flag; the in-flight conversion completes, then the field is reconverted; no update is lost.
REQ-017 A raw value >= 100 SHALL produce blank (8'hFF) on both digits of that field instead of BCD; conversion is skipped.
REQ-018 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; at wrap the digit index advances 0..5 and wraps to 0.
REQ-019 Digit map:
- index 0/1: seco ones/tens
- index 2/3: minu ones/tens
- index 4/5: hour ones/tens
REQ-020 seg and sel SHALL be registered and change on the same clk edge (one cycle after the index change), with no overlap between digits.
REQ-021 Encoding: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 (hex, dp off).
REQ-022 dp (seg[7]=0) SHALL be driven only on digit indices 2 and 4 (field separators), subject to REQ-027/028.

Reset
REQ-023 While rst is high: seg = 8'hFF, sel = 6'h3F, scan counter = 0, digit index = 0, FSM = IDLE, all pending flags = 0, all raw and digit registers = 0.
REQ-024 After rst falls the display SHALL show 00 00 00, starting on index 0 one cycle after the first scan wrap.
REQ-025 rst asserted mid-conversion SHALL abort it immediately; no partial digit write SHALL occur.

Configuration
REQ-026 Macro SEG_SCAN_DP_BLINK_EN selects the separator behaviour.
REQ-027 With SEG_SCAN_DP_BLINK_EN defined: a dp-phase bit toggles on every seco_vld pulse (reset value 1 = lit), and separators are lit only while it is 1.
REQ-028 Without SEG_SCAN_DP_BLINK_EN: separators are always lit, and no dp-phase register exists.

Verification (SCAN_DIV=4)
REQ-029 Release rst, no vld -> sel cycles 3E,3D,3B,37,2F,1F every 4 cycles; seg C0 on all, dp low on indices 2 and 4.
REQ-030 seco=8'd37 with seco_vld -> within 12 cycles index 0 shows F8 and index 1 shows B0.
REQ-031 hour=23, minu=59, seco=59 all vld same cycle -> all digits correct within 36 cycles, converted in order sec, min, hour.
REQ-032 seco_vld with 5, then seco_vld with 6 three cycles later -> final ones digit is 82 (6), tens C0.
REQ-033 minu=8'd150 with minu_vld -> indices 2 and 3 show FF (dp still lit on index 2); assert rst mid-scan -> seg FF, sel 3F immediately.
REQ-034 Build with SEG_SCAN_DP_BLINK_EN and pulse seco_vld twice -> dp off after the first pulse, on after the second; build without it -> dp is constant.

Source files
------------

// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan - six-digit multiplexed 7-segment driver for an HH.MM.SS clock.
//
// Binary hour/minute/second values are captured on their valid pulses and
// converted to BCD by one shared repeated-subtraction converter (one
// subtraction per cycle, priority seco > minu > hour). A scan counter walks
// the six digits, and segments/select are registered together at each wrap.
// A raw value of 100 or more blanks both digits of its field.
//
// Configuration macro:
//   SEG_SCAN_DP_BLINK_EN - separator dots toggle on every seco_vld pulse
//                          (lit after reset); undefined = always lit.
//
// Parameters:
//   SCAN_DIV - clk cycles each digit stays selected
//   DIGITS   - number of display digits, must be 6
//
// Ports:
//   clk                        system clock, rising edge
//   rst                        asynchronous active-high reset
//   hour / minu / seco  [7:0]  binary field values
//   hour_vld / minu_vld /      one-cycle pulse: matching value changed
//   seco_vld
//   seg                 [7:0]  active-low segments, [6:0] = g..a, [7] = dp
//   sel                 [5:0]  active-low one-hot digit select, [0] = rightmost
// -----------------------------------------------------------------------------
module seg_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hour,
  input  logic [7:0] minu,
  input  logic [7:0] seco,
  input  logic       hour_vld,
  input  logic       minu_vld,
  input  logic       seco_vld,
  output logic [7:0] seg,
  output logic [5:0] sel
);

  localparam int               CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]       IDX_MAX = 3'(DIGITS - 1);
  // Digit-register code that encodes to an all-dark digit.
  localparam logic [3:0]       BLANK   = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_WRITE} state_t;

  // Field order everywhere: 0 = seco, 1 = minu, 2 = hour.
  logic [7:0] val [3];
  logic [2:0] vld;

  state_t     state_q, state_d;
  logic [2:0] pend_q,  pend_d;
  logic [7:0] raw_q [3];
  logic [7:0] raw_d [3];
  logic [1:0] fld_q,   fld_d;
  logic [7:0] work_q,  work_d;
  logic [3:0] tens_q,  tens_d;
  logic       blank_q, blank_d;
  logic [3:0] digit_q [6];
  logic [3:0] digit_d [6];
  logic [1:0] pick;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [5:0]       sel_q, sel_d;
  logic             wrap;
  logic             dp_on;

  assign val[0] = seco;
  assign val[1] = minu;
  assign val[2] = hour;
  assign vld    = {hour_vld, minu_vld, seco_vld};

  function automatic logic [7:0] enc7(input logic [3:0] d);
    case (d)
      4'd0:    enc7 = 8'hC0;
      4'd1:    enc7 = 8'hF9;
      4'd2:    enc7 = 8'hA4;
      4'd3:    enc7 = 8'hB0;
      4'd4:    enc7 = 8'h99;
      4'd5:    enc7 = 8'h92;
      4'd6:    enc7 = 8'h82;
      4'd7:    enc7 = 8'hF8;
      4'd8:    enc7 = 8'h80;
      4'd9:    enc7 = 8'h90;
      default: enc7 = 8'hFF;
    endcase
  endfunction

  // Highest-priority pending field.
  always_comb begin
    if (pend_q[0])      pick = 2'd0;
    else if (pend_q[1]) pick = 2'd1;
    else                pick = 2'd2;
  end

  // Capture, pending flags and the BCD converter.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d = state_q;
    pend_d  = pend_q;
    raw_d   = raw_q;
    fld_d   = fld_q;
    work_d  = work_q;
    tens_d  = tens_q;
    blank_d = blank_q;
    digit_d = digit_q;

    for (int f = 0; f < 3; f++) begin
      if (vld[f]) raw_d[f] = val[f];
    end

    unique case (state_q)
      S_IDLE: begin
        if (pend_q != 3'b000) begin
          fld_d        = pick;
          pend_d[pick] = 1'b0;
          work_d       = raw_q[pick];
          tens_d       = 4'd0;
          blank_d      = (raw_q[pick] >= 8'd100);
          state_d      = (raw_q[pick] >= 8'd100) ? S_WRITE : S_CONV;
        end
      end
      S_CONV: begin
        if (work_q >= 8'd10) begin
          work_d = work_q - 8'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        digit_d[{fld_q, 1'b0}] = blank_q ? BLANK : work_q[3:0];
        digit_d[{fld_q, 1'b1}] = blank_q ? BLANK : tens_q;
        state_d                = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh pulse re-arms the field even if it was just picked, so an
    // update arriving during its own conversion is reconverted afterwards.
    pend_d = pend_d | vld;
  end

`ifdef SEG_SCAN_DP_BLINK_EN
  logic dp_ph_q, dp_ph_d;

  always_comb dp_ph_d = dp_ph_q ^ seco_vld;
  assign dp_on = dp_ph_q;
`else
  assign dp_on = 1'b1;
`endif

  // Scan counter; outputs reload only at wrap so seg and sel always move
  // together and never show a mix of two digits.
  always_comb begin
    wrap  = (cnt_q == CNT_MAX);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    seg_d = seg_q;
    sel_d = sel_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
      sel_d = ~(6'b000001 << idx_q);
      seg_d = enc7(digit_q[idx_q]);
      if (dp_on && (idx_q == 3'd2 || idx_q == 3'd4)) seg_d[7] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      // NOTE: the raw and digit arrays are a few flops, not RAM, and the
      // display must read 00 00 00 out of reset, so they are reset too.
      raw_q   <= '{default: '0};
      digit_q <= '{default: '0};
      fld_q   <= '0;
      work_q  <= '0;
      tens_q  <= '0;
      blank_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 8'hFF;
      sel_q   <= 6'h3F;
`ifdef SEG_SCAN_DP_BLINK_EN
      dp_ph_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      raw_q   <= raw_d;
      digit_q <= digit_d;
      fld_q   <= fld_d;
      work_q  <= work_d;
      tens_q  <= tens_d;
      blank_q <= blank_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
`ifdef SEG_SCAN_DP_BLINK_EN
      dp_ph_q <= dp_ph_d;
`endif
    end
  end

  assign seg = seg_q;
  assign sel = sel_q;

endmodule

// File: tb/tb_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_scan - self-checking bench for seg_scan with SCAN_DIV = 4.
//
// The reference model keeps the latest valid value of each field and derives
// the displayed digit arithmetically (v % 10, v / 10, blank for v >= 100).
// Which slot is shown follows from the number of clocks since reset release.
// sel is compared every cycle; seg is compared for slots loaded long enough
// after the last valid pulse that any conversion has finished.
// -----------------------------------------------------------------------------
module tb_seg_scan;

  localparam int SD     = 4;
  localparam int SETTLE = 60;

  localparam logic [7:0] ENC [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       clk;
  logic       rst;
  logic [7:0] hour, minu, seco;
  logic       hour_vld, minu_vld, seco_vld;
  logic [7:0] seg;
  logic [5:0] sel;

  int n_tests = 0;
  int n_fail  = 0;

  seg_scan #(.SCAN_DIV(SD), .DIGITS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .hour     (hour),
    .minu     (minu),
    .seco     (seco),
    .hour_vld (hour_vld),
    .minu_vld (minu_vld),
    .seco_vld (seco_vld),
    .seg      (seg),
    .sel      (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int  e;            // clock edges since reset release
  int  last_vld_e;   // edge number of the latest valid pulse
  int  m_val [3];    // latest captured value: 0 seco, 1 minu, 2 hour
  bit  dp_ph;
  bit  exp_on;       // a digit slot has been loaded since reset
  int  exp_idx;
  bit  exp_settled;
  int  exp_vals [3];
  bit  exp_dp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e           <= 0;
      last_vld_e  <= -1000;
      m_val       <= '{0, 0, 0};
      dp_ph       <= 1'b1;
      exp_on      <= 1'b0;
      exp_idx     <= 0;
      exp_settled <= 1'b1;
      exp_vals    <= '{0, 0, 0};
      exp_dp      <= 1'b1;
    end else begin
      e <= e + 1;
      if ((e + 1) % SD == 0) begin
        exp_on      <= 1'b1;
        exp_idx     <= ((e + 1) / SD - 1) % 6;
        exp_settled <= (e + 1 - last_vld_e) > SETTLE;
        exp_vals    <= m_val;
        exp_dp      <= dp_ph;
      end
      if (seco_vld) m_val[0] <= int'(seco);
      if (minu_vld) m_val[1] <= int'(minu);
      if (hour_vld) m_val[2] <= int'(hour);
      if (seco_vld || minu_vld || hour_vld) last_vld_e <= e + 1;
      if (seco_vld) dp_ph <= ~dp_ph;
    end
  end

  function automatic logic [7:0] model_seg(input int idx, input int v, input bit ph);
    logic [7:0] base;
    bit         lit;
    if (v >= 100)       base = 8'hFF;
    else if (idx % 2)   base = ENC[v / 10];
    else                base = ENC[v % 10];
`ifdef SEG_SCAN_DP_BLINK_EN
    lit = ph;
`else
    lit = 1'b1;
`endif
    if ((idx == 2 || idx == 4) && lit) base = base & 8'h7F;
    return base;
  endfunction

  // Compare process: runs on the opposite edge every cycle outside reset.
  always @(negedge clk) begin
    logic [5:0] exp_sel;
    if (!rst) begin
      if (!exp_on) begin
        check("idle_sel", {2'b00, sel}, 8'h3F);
        check("idle_seg", seg, 8'hFF);
      end else begin
        exp_sel = ~(6'b000001 << exp_idx);
        check("scan_sel", {2'b00, sel}, {2'b00, exp_sel});
        if (exp_settled)
          check("scan_seg", seg, model_seg(exp_idx, exp_vals[exp_idx / 2], exp_dp));
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic pulse(input logic [2:0] m, input logic [7:0] h,
                       input logic [7:0] mi, input logic [7:0] s);
    @(negedge clk);
    hour = h;
    minu = mi;
    seco = s;
    {hour_vld, minu_vld, seco_vld} = m;
    @(negedge clk);
    {hour_vld, minu_vld, seco_vld} = 3'b000;
    // Values without a pulse must be ignored, so leave garbage behind.
    hour = 8'($urandom);
    minu = 8'($urandom);
    seco = 8'($urandom);
  endtask

  // Wait (bounded) for a settled slot showing digit idx; ends on a negedge.
  task automatic wait_slot(input int idx);
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_on && exp_settled && exp_idx == idx) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("wait_slot_timeout", 8'd0, 8'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] m;
    rst  = 1'b1;
    hour = 8'd0;
    minu = 8'd0;
    seco = 8'd0;
    {hour_vld, minu_vld, seco_vld} = 3'b000;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_seg", seg, 8'hFF);
    check("rst_sel", {2'b00, sel}, 8'h3F);
    rst = 1'b0;

    // Blank scan after reset: 00 00 00 with separators.
    wait_slot(0);
    check("zero_sel0", {2'b00, sel}, 8'h3E);
    check("zero_seg0", seg, 8'hC0);
    wait_slot(2);
    check("zero_seg2", seg, 8'h40);
    wait_slot(5);
    check("zero_sel5", {2'b00, sel}, 8'h1F);
    check("zero_seg5", seg, 8'hC0);

    // Single field.
    pulse(3'b001, 8'($urandom), 8'($urandom), 8'd37);
    wait_slot(0);
    check("s37_ones", seg, 8'hF8);
    wait_slot(1);
    check("s37_tens", seg, 8'hB0);

    // All three fields at once.
    pulse(3'b111, 8'd23, 8'd59, 8'd59);
    wait_slot(5);
    check("h23_tens", seg, 8'hA4);
    wait_slot(4);
    check("h23_ones_dp", seg, 8'h30);
    wait_slot(3);
    check("m59_tens", seg, 8'h92);
    wait_slot(0);
    check("s59_ones", seg, 8'h90);

    // Re-pulse three cycles after the first.
    pulse(3'b001, 8'd0, 8'd0, 8'd5);
    @(negedge clk);
    pulse(3'b001, 8'd0, 8'd0, 8'd6);
    wait_slot(0);
    check("repulse_ones", seg, 8'h82);
    wait_slot(1);
    check("repulse_tens", seg, 8'hC0);

    // Out-of-range value blanks its field; separator stays.
    pulse(3'b010, 8'd0, 8'd150, 8'd0);
    wait_slot(2);
    check("m150_ones_dp", seg, 8'h7F);
    wait_slot(3);
    check("m150_tens", seg, 8'hFF);

    // Separator behaviour on seco_vld pulses.
    pulse(3'b001, 8'd0, 8'd0, 8'd6);
    wait_slot(2);
`ifdef SEG_SCAN_DP_BLINK_EN
    check("dp_after_1", seg, 8'hFF);
`else
    check("dp_after_1", seg, 8'h7F);
`endif
    pulse(3'b001, 8'd0, 8'd0, 8'd6);
    wait_slot(2);
    check("dp_after_2", seg, 8'h7F);

    // Randomised traffic, including same-field re-pulses and blanks.
    for (int r = 0; r < 30; r++) begin
      m = 3'($urandom_range(1, 7));
      pulse(m, 8'($urandom_range(0, 130)), 8'($urandom_range(0, 130)),
            8'($urandom_range(0, 130)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        pulse(3'($urandom_range(1, 7)), 8'($urandom_range(0, 99)),
              8'($urandom_range(0, 99)), 8'($urandom_range(0, 99)));
      end
      repeat ($urandom_range(0, 120)) @(negedge clk);
    end
    repeat (100) @(negedge clk);

    // Reset in the middle of a conversion.
    pulse(3'b001, 8'd0, 8'd0, 8'd99);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_seg", seg, 8'hFF);
    check("midrst_sel", {2'b00, sel}, 8'h3F);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_slot(0);
    check("postrst_ones", seg, 8'hC0);
    wait_slot(1);
    check("postrst_tens", seg, 8'hC0);
    repeat (8 * SD) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
